// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request and response handshake bundle between
// the datapath memory stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding RV32I data-memory responder with a fixed
// access latency. Byte/half/word loads (sign or zero extended) and stores.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses are flagged with rsp_err instead of being force-aligned.
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam int         AW       = ADDR_WIDTH + 2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
    localparam bit         DIRECT   = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [3:0]      cnt_r;
    logic            we_r;
    logic [AW-1:0]   addr_r;
    logic [2:0]      funct3_r;
    logic [31:0]     wdata_r;
    logic [31:0]     rdata_r;
    logic            err_r;
    logic [31:0]     mem_r [DEPTH];

    logic            req_ready_s;
    logic            rsp_valid_s;
    logic            accept_s;
    logic            commit_s;
    logic            cur_we_s;
    logic [AW-1:0]   cur_addr_s;
    logic [2:0]      cur_funct3_s;
    logic [31:0]     cur_wdata_s;
    logic [ADDR_WIDTH-1:0] idx_s;
    logic [1:0]      off_s;
    logic            illegal_s;
    logic            err_s;
    logic            unused_addr_s;

    // Upper address bits wrap away; they are deliberately ignored.
    assign unused_addr_s = ^bus.req_addr[31:AW];

    // Extract and extend the addressed lane of a memory word for a load.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h000000, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0000, h};
            3'b010:  return word;
            default: return 32'h00000000;
        endcase
    endfunction

    // Merge right-aligned store data into the selected lanes of the old word.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wd,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [31:0] w;
        w = old;
        case (f3)
            3'b000: begin
                case (off)
                    2'b00:   w[7:0]   = wd[7:0];
                    2'b01:   w[15:8]  = wd[7:0];
                    2'b10:   w[23:16] = wd[7:0];
                    2'b11:   w[31:24] = wd[7:0];
                    default: w = old;
                endcase
            end
            3'b001: begin
                if (off[1]) w[31:16] = wd[15:0];
                else        w[15:0]  = wd[15:0];
            end
            3'b010:  w = wd;
            default: w = old;
        endcase
        return w;
    endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
    // A half on an odd byte or a word off a word boundary is misaligned.
    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return (a != 2'b00);
            default: return 1'b0;
        endcase
    endfunction
`endif

    // Output decode from state; the port is closed while reset is asserted.
    always_comb begin
        req_ready_s = (state_r == IDLE) && !reset;
        rsp_valid_s = (state_r == RESP);
        accept_s    = bus.req_valid && req_ready_s;
        if (state_r == WAIT) begin
            commit_s = (cnt_r == 4'd0);
        end else if (state_r == IDLE) begin
            commit_s = DIRECT && accept_s;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Operation seen by the commit edge: live bus in IDLE (latency 1), else captured.
    always_comb begin
        if (state_r == IDLE) begin
            cur_we_s     = bus.req_we;
            cur_addr_s   = bus.req_addr[AW-1:0];
            cur_funct3_s = bus.req_funct3;
            cur_wdata_s  = bus.req_wdata;
        end else begin
            cur_we_s     = we_r;
            cur_addr_s   = addr_r;
            cur_funct3_s = funct3_r;
            cur_wdata_s  = wdata_r;
        end
        idx_s = cur_addr_s[AW-1:2];
    end

    // Legality check and lane offset (force-aligned when not trapping).
    always_comb begin
        illegal_s = 1'b0;
        off_s     = cur_addr_s[1:0];
        if (cur_we_s) begin
            case (cur_funct3_s)
                3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
                default:                illegal_s = 1'b1;
            endcase
        end else begin
            case (cur_funct3_s)
                3'b011, 3'b110, 3'b111: illegal_s = 1'b1;
                default:                illegal_s = 1'b0;
            endcase
        end
        case (cur_funct3_s[1:0])
            2'b00:   off_s = cur_addr_s[1:0];
            2'b01:   off_s = {cur_addr_s[1], 1'b0};
            2'b10:   off_s = 2'b00;
            default: off_s = cur_addr_s[1:0];
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        err_s = illegal_s || is_misaligned(cur_funct3_s, cur_addr_s[1:0]);
`else
        err_s = illegal_s;
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_next_s = DIRECT ? RESP : WAIT;
                else          state_next_s = IDLE;
            end
            WAIT: begin
                if (cnt_r == 4'd0) state_next_s = RESP;
                else               state_next_s = WAIT;
            end
            RESP: begin
                if (bus.rsp_ready) state_next_s = IDLE;
                else               state_next_s = RESP;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Request capture, latency counter and registered response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r    <= 4'd0;
            we_r     <= 1'b0;
            addr_r   <= '0;
            funct3_r <= 3'b000;
            wdata_r  <= 32'h00000000;
            rdata_r  <= 32'h00000000;
            err_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                cnt_r    <= CNT_LOAD;
                we_r     <= bus.req_we;
                addr_r   <= bus.req_addr[AW-1:0];
                funct3_r <= bus.req_funct3;
                wdata_r  <= bus.req_wdata;
            end else if (state_r == WAIT && cnt_r != 4'd0) begin
                cnt_r <= cnt_r - 4'd1;
            end
            if (commit_s) begin
                err_r <= err_s;
                if (cur_we_s || err_s) rdata_r <= 32'h00000000;
                else rdata_r <= load_extract(mem_r[idx_s], cur_funct3_s, off_s);
            end
        end
    end

    // Store commit on the edge entering RESP; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit_s && cur_we_s && !err_s && !reset) begin
            mem_r[idx_s] <= store_merge(mem_r[idx_s], cur_wdata_s, cur_funct3_s, off_s);
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_s;
    assign bus.rsp_rdata = rdata_r;
    assign bus.rsp_err   = err_r;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for dmem_responder (LATENCY = 2).
module tb_dmem_responder;
    localparam int LAT = 2;
    localparam int AW  = 10;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;
    logic [32:0] exp_q[$];

    dmem_responder_if bus ();

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, check latency, pop the expected response, optionally stall.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] wd,
                          input logic [31:0] exp_d, input logic exp_e, input int stall);
        int n;
        logic [32:0] e;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_funct3 = f3;
        bus.req_wdata  = wd;
        exp_q.push_back({exp_e, exp_d});
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, LAT);
        e = exp_q.pop_front();
        check({tag, "_rdata"}, bus.rsp_rdata, e[31:0]);
        check({tag, "_err"}, {31'd0, bus.rsp_err}, {31'd0, e[32]});
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_stall_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
            check({tag, "_stall_rdata"}, bus.rsp_rdata, e[31:0]);
            check({tag, "_stall_ready"}, {31'd0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, "_done_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        check({tag, "_done_ready"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        compared       = 0;
        mismatched     = 0;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_funct3 = 3'b000;
        bus.req_wdata  = 32'h0;
        bus.rsp_ready  = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rdata", bus.rsp_rdata, 32'h0);
        check("rst_err", {31'd0, bus.rsp_err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

        do_req("sw10",  1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        do_req("lw10",  1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        do_req("sb13",  1'b1, 32'h13, 3'b000, 32'h00000080, 32'h0, 1'b0, 0);
        do_req("lb13",  1'b0, 32'h13, 3'b000, 32'h0, 32'hFFFFFF80, 1'b0, 0);
        do_req("lbu13", 1'b0, 32'h13, 3'b100, 32'h0, 32'h00000080, 1'b0, 0);
        do_req("lw10b", 1'b0, 32'h10, 3'b010, 32'h0, 32'h80ADBEEF, 1'b0, 5);
        do_req("lh12",  1'b0, 32'h12, 3'b001, 32'h0, 32'hFFFF80AD, 1'b0, 0);
        do_req("lhu12", 1'b0, 32'h12, 3'b101, 32'h0, 32'h000080AD, 1'b0, 0);
        do_req("lb11",  1'b0, 32'h11, 3'b000, 32'h0, 32'hFFFFFFBE, 1'b0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        do_req("lh11",  1'b0, 32'h11, 3'b001, 32'h0, 32'h0, 1'b1, 0);
        do_req("lw12",  1'b0, 32'h12, 3'b010, 32'h0, 32'h0, 1'b1, 0);
`else
        do_req("lh11",  1'b0, 32'h11, 3'b001, 32'h0, 32'hFFFFBEEF, 1'b0, 0);
        do_req("lw12",  1'b0, 32'h12, 3'b010, 32'h0, 32'h80ADBEEF, 1'b0, 0);
`endif
        do_req("ld011", 1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1, 0);
        do_req("st011", 1'b1, 32'h10, 3'b011, 32'h11223344, 32'h0, 1'b1, 0);
        do_req("lw10c", 1'b0, 32'h10, 3'b010, 32'h0, 32'h80ADBEEF, 1'b0, 0);
        do_req("sh16",  1'b1, 32'h16, 3'b001, 32'hFFFF1234, 32'h0, 1'b0, 0);
        do_req("lhu16", 1'b0, 32'h16, 3'b101, 32'h0, 32'h00001234, 1'b0, 0);
        do_req("swwrap", 1'b1, 32'h10 + 32'(4 * (1 << AW)), 3'b010, 32'hCAFEF00D, 32'h0, 1'b0, 0);
        do_req("lwwrap", 1'b0, 32'h10, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0, 0);
        do_req("sw20",  1'b1, 32'h20, 3'b010, 32'h11111111, 32'h0, 1'b0, 0);

        // Store aborted by reset while waiting: no response, no write.
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_addr   = 32'h20;
        bus.req_funct3 = 3'b010;
        bus.req_wdata  = 32'h12345678;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("abort_wait_valid", {31'd0, bus.rsp_valid}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_rst_ready", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        check("abort_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_valid", {31'd0, bus.rsp_valid}, 32'd0);
        end
        do_req("lw20",  1'b0, 32'h20, 3'b010, 32'h0, 32'h11111111, 1'b0, 0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V datapath: the far end of the core's load/store port. It accepts one load or store request at a time over a valid/ready handshake and applies a fixed, parameterised access latency. It performs RV32I byte, halfword and word access with sign or zero extension, and returns the result over a second valid/ready handshake. It sits between the datapath's memory stage and the data SRAM, and replaces the zero-latency combinational memory model in system simulation.

## Interface
- ADDR_WIDTH, 10: number of word-index bits; memory holds 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2: cycles from request acceptance to rsp_valid; legal range 1..15.
- clk  in  1  rising-edge clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  request was illegal (see Operation); valid with rsp_valid.

## Operation
- States: IDLE, WAIT, RESP. req_ready = 1 only in IDLE and 0 while reset is high. rsp_valid = 1 only in RESP.
- IDLE: on req_valid && req_ready, capture we/addr/funct3/wdata and load the counter with LATENCY-1. Go to WAIT, or to RESP directly if LATENCY = 1.
- WAIT: decrement the counter each cycle. At 0, go to RESP on the next edge.
- Entering RESP:
  - Stores commit to memory on this edge. Byte/half lanes are selected by addr[1:0]; unselected bytes are unchanged.
  - Loads register rsp_rdata on this edge.
- RESP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready. On rsp_valid && rsp_ready, return to IDLE.
- Only one request is outstanding at a time. No request is accepted on the response-handshake edge.
- Word index = addr[ADDR_WIDTH+1:2]. Higher address bits are ignored, so addresses wrap modulo 4·2**ADDR_WIDTH bytes.
- Loads:
  - funct3 000 LB and 100 LBU: byte at addr[1:0].
  - funct3 001 LH and 101 LHU: half at addr[1].
  - funct3 010 LW: full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Stores: funct3 000 SB, 001 SH, 010 SW.
- Illegal funct3 (loads 011/110/111; stores anything other than 000/001/010): rsp_err = 1, rsp_rdata = 0, no memory write.
- Reset:
  - State goes to IDLE; rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - An in-flight request is discarded. A store not yet committed is dropped.
  - Memory contents are not cleared by reset.

## Timing
- Request accepted at edge N: rsp_valid rises after edge N+LATENCY.
- The store is visible to a load accepted at or after edge N+LATENCY+1.
- Best-case throughput is one request per LATENCY+2 cycles (accept, LATENCY cycles, response handshake, return to IDLE).
- rsp_ready held low stalls indefinitely in RESP; outputs stay stable.
- req_valid may be held high across the whole transaction; only the IDLE-state handshake samples it.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: a misaligned access gives rsp_err = 1, rsp_rdata = 0, and no memory write. Misaligned means a half with addr[0] = 1, or a word with addr[1:0] ≠ 0. Response timing is unchanged.
- DMEM_MISALIGN_TRAP_EN undefined: misaligned addresses are force-aligned (half clears addr[0]; word clears addr[1:0]). The access completes normally with rsp_err = 0. rsp_err then flags only illegal funct3.

## Test plan
- Reset, then SW 0xDEADBEEF to 0x10, then LW 0x10 (LATENCY = 2) → rsp_valid 2 cycles after each accept; rdata 0xDEADBEEF, err 0.
- SB 0x80 to 0x13, then LB 0x13 and LBU 0x13 → 0xFFFFFF80 and 0x00000080. LW 0x10 → 0x80ADBEEF.
- Hold rsp_ready = 0 for 5 cycles in RESP → rsp_valid/rdata stable, req_ready = 0. Release → IDLE next cycle, req_ready = 1.
- LH 0x11:
  - with DMEM_MISALIGN_TRAP_EN: err = 1, rdata = 0.
  - without: reads the half at 0x10, sign-extended. With 0x80ADBEEF at 0x10 → 0xFFFFBEEF, err 0.
- Load with funct3 011 → err = 1, rdata = 0. SW to address 0x10 + 4·2**ADDR_WIDTH, then LW 0x10 → the written data (wrap).
- Assert reset during WAIT of SW 0x12345678 to 0x20 → no rsp_valid; after reset, LW 0x20 returns the prior contents.
